// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX and TX paths: receiver state
// encoding, frame width, default bit period and a 3-input majority helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // 115200 baud from the 10 MHz system clock
  localparam int UART_CLK_CYCLES_DEFAULT = 87;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input. RST_VAL sets the
// value both flops take in reset (1 for idle-high lines such as UART RX).
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first, idle-high line. Delivers bytes through a
// valid/ack holding register and pulses framing_err / overrun.
// Build option: define UART_RX_MAJORITY_EN to take each start/data/stop
// sample as a 3-cycle majority vote around mid-bit (decision one cycle later).
//
// state | meaning
// IDLE  | line idle, waiting for rx_s=0
// START | timing to mid start bit, rejecting false starts
// DATA  | sampling 8 data bits, one per bit period
// STOP  | timing to mid stop bit; commit byte or flag framing error
// BREAK | stop bit was 0; waiting for the line to return high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_CYCLES = UART_CLK_CYCLES_DEFAULT,
  parameter int CTR_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       framing_err,
  output logic       overrun
);

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DELAY = 1;
`else
  localparam int MAJ_DELAY = 0;
`endif

  // Down-counter loads: sample when the counter reaches zero
  localparam logic [CTR_W-1:0] HALF_LOAD = CTR_W'(CLK_CYCLES / 2 + MAJ_DELAY);
  localparam logic [CTR_W-1:0] BIT_LOAD  = CTR_W'(CLK_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e            state_q, state_d;
  logic [CTR_W-1:0]          ctr_q, ctr_next;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_s, rx_bit;
  logic                      ctr_load, sample, commit, frame_bad, tc;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  // Keep the two previous synchronized samples for the majority vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_hist <= 2'b11;
    else        rx_hist <= {rx_hist[0], rx_s};
  end

  assign rx_bit = maj3(rx_hist[1], rx_hist[0], rx_s);
`else
  assign rx_bit = rx_s;
`endif

  assign tc = (ctr_q == '0);

  // Next-state and sample strobes
  always_comb begin
    state_d   = state_q;
    ctr_load  = 1'b0;
    sample    = 1'b0;
    commit    = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d  = START;
          ctr_load = 1'b1;
        end
      end
      START: begin
        if (tc) begin
          if (rx_bit) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            ctr_load = 1'b1;
          end
        end
      end
      DATA: begin
        if (tc) begin
          sample   = 1'b1;
          ctr_load = 1'b1;
          if (idx_q == LAST_IDX) state_d = STOP;
        end
      end
      STOP: begin
        if (tc) begin
          if (rx_bit) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ctr_next = (state_d == START) ? HALF_LOAD : BIT_LOAD;
  end

  // State register, bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      idx_q   <= '0;
      shreg   <= '0;
    end else begin
      state_q <= state_d;
      if (ctr_load)          ctr_q <= ctr_next;
      else if (ctr_q != '0)  ctr_q <= ctr_q - CTR_W'(1);
      if (state_q == START)  idx_q <= '0;
      else if (sample)       idx_q <= idx_q + 3'd1;
      if (sample)            shreg <= {rx_bit, shreg[UART_DATA_BITS-1:1]};
    end
  end

  // Holding register, handshake and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      overrun     <= 1'b0;
      if (commit) begin
        if (!valid) begin
          data  <= shreg;
          valid <= 1'b1;
        end else if (ack) begin
          data  <= shreg;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven cycle by cycle and
// the expected output event is queued at frame start; a negedge monitor pops
// and checks each data/framing/overrun event the DUT presents.
module tb_uart_receiver;

  localparam int CC   = 87;
  localparam int HALF = CC / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ  = 1;
  localparam logic [7:0] EXP_96 = 8'h96;
`else
  localparam int MAJ  = 0;
  localparam logic [7:0] EXP_96 = 8'h69;  // every data sample hits the glitch
`endif
  // clock edges from the edge that first captures the falling line to the stop sample
  localparam int LAT = 829 + MAJ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, framing_err, overrun;

  uart_receiver #(.CLK_CYCLES(CC), .CTR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .data        (data),
    .valid       (valid),
    .ack         (ack),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum {EV_NONE, EV_DATA, EV_FERR, EV_OVR} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] d;
    int         t_lo;
    int         t_hi;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report(input ev_e k, input logic [7:0] d);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s data %0h at cycle %0d, expected none", k.name(), d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || (k != EV_FERR && e.d !== d) || cyc < e.t_lo || cyc > e.t_hi) begin
        n_fail++;
        $display("FAIL event: got %s data %0h at cycle %0d, expected %s data %0h in cycles %0d..%0d",
                 k.name(), d, cyc, e.kind.name(), e.d, e.t_lo, e.t_hi);
      end
    end
  endtask

  // Monitor: turn DUT outputs into events and check them against the queue
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (framing_err) report(EV_FERR, data);
      if (overrun)     report(EV_OVR, data);
      if (valid && (!pv || data !== pd)) report(EV_DATA, data);
    end
    pv = valid;
    pd = data;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 10-bit frame; queue the expected event at frame start
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch,
                            input ev_e kind, input logic [7:0] exp_d);
    int   t0;
    int   lb;
    logic v;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (kind != EV_NONE) sb.push_back('{kind, exp_d, t0 + LAT, t0 + LAT + 2});
    for (int c = 0; c < 10 * CC; c++) begin
      lb = c / CC;
      if (lb == 0)      v = 1'b0;
      else if (lb == 9) v = stop_v;
      else              v = b[lb-1];
      if (glitch && lb >= 1 && lb <= 8 && (c % CC) == HALF + 1) v = ~v;
      uart_rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 2 * CC) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ts;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", data, 8'h00);
    check("reset_flags", {valid, framing_err, overrun}, 3'b000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    // Single frame 0x41 with latency window, then ack
    send_frame(8'h41, 1'b1, 1'b0, EV_DATA, 8'h41);
    drain("drain_41");
    check("data_41", {valid, data}, {1'b1, 8'h41});
    pulse_ack();
    @(negedge clk);
    check("ack_clears_valid", valid, 1'b0);
    #1;
    pulse_ack();
    @(negedge clk);
    check("ack_ignored_when_empty", valid, 1'b0);
    #1;

    // False start glitch, then 0x5A
    uart_rx = 1'b0;
    idle(20);
    uart_rx = 1'b1;
    idle(3 * CC);
    check("false_start_no_valid", valid, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, EV_DATA, 8'h5A);
    drain("drain_5a");
    check("data_5a", {valid, data}, {1'b1, 8'h5A});
    pulse_ack();

    // Framing error with held-low line, then 0x33
    send_frame(8'hFF, 1'b0, 1'b0, EV_FERR, 8'h00);
    idle(2000);
    check("break_no_valid", valid, 1'b0);
    check("break_ferr_seen", sb.size(), 0);
    uart_rx = 1'b1;
    idle(CC);
    send_frame(8'h33, 1'b1, 1'b0, EV_DATA, 8'h33);
    drain("drain_33");
    check("data_33", {valid, data}, {1'b1, 8'h33});
    pulse_ack();

    // Back-to-back without ack: overrun keeps first byte
    send_frame(8'h11, 1'b1, 1'b0, EV_DATA, 8'h11);
    send_frame(8'h22, 1'b1, 1'b0, EV_OVR, 8'h11);
    drain("drain_overrun");
    check("overrun_keeps_old", {valid, data}, {1'b1, 8'h11});
    pulse_ack();
    idle(2);

    // Back-to-back with ack in the commit cycle: new byte replaces old
    send_frame(8'h11, 1'b1, 1'b0, EV_DATA, 8'h11);
    ts = cyc + 1;
    fork
      send_frame(8'h22, 1'b1, 1'b0, EV_DATA, 8'h22);
      begin
        while (cyc < ts + LAT) begin
          @(posedge clk);
          #1;
        end
        pulse_ack();
      end
    join
    drain("drain_ack_commit");
    check("ack_commit_loads_new", {valid, data}, {1'b1, 8'h22});
    check("ack_commit_no_overrun", overrun, 1'b0);

    // Reset during bit 4 of 0xA5 (byte 0x22 still held)
    ts = cyc + 1;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, EV_NONE, 8'h00);
      begin
        while (cyc < ts + 5 * CC + 40) begin
          @(posedge clk);
          #1;
        end
        rst_n = 1'b0;
        #2;
        check("async_reset_outputs", {data, valid, framing_err, overrun}, 11'h000);
      end
    join
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2 * CC);
    check("post_reset_no_valid", valid, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, EV_DATA, 8'hC3);
    drain("drain_c3");
    check("data_c3", {valid, data}, {1'b1, 8'hC3});
    pulse_ack();
    idle(2);

    // Single-cycle glitch at every data-bit midpoint of 0x96
    send_frame(8'h96, 1'b1, 1'b1, EV_DATA, EXP_96);
    drain("drain_96");
    check("data_96_glitch", {valid, data}, {1'b1, EXP_96});
    pulse_ack();

    idle(CC);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
